// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo_buf: small byte FIFO with combinational head read and occupancy count.
// Latency: a pushed entry is visible at pop_dat one cycle after the push edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module uart_tx_fifo_buf #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_vld,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_vld) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_vld)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_vld, pop_vld})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && push_vld) mem_q[wr_ptr_q] <= push_dat;
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;
endmodule

// uart_tx_fifo: buffered UART transmitter, 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined.
// Latency: a byte accepted into an idle, empty block starts its start bit one cycle later.
// Backpressure: wr_ready falls when the FIFO is full or ena is low; a frame in flight always completes.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic          push;
    logic          pop;
    logic          bit_end;
    logic          can_load;
    logic [7:0]    head_dat;
    logic [CW-1:0] count;

    assign wr_ready = ena && (count < DEPTH_C);
    assign push     = wr_valid && wr_ready;
    assign bit_end  = (baud_q == BAUD_LAST);
    assign can_load = ena && (count != '0);

    uart_tx_fifo_buf #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push),
        .push_dat (wr_data),
        .pop_vld  (pop),
        .pop_dat  (head_dat),
        .count    (count)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + BAUD_ONE;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (can_load) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d    = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    // Chaining straight into START keeps back-to-back frames gap-free.
                    if (can_load) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
        if (pop) begin
            shift_d = head_dat;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head_dat;
`endif
        end
    end

    // Line level is derived from the next state so tx and busy change on the same edge as the FSM.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4); a line monitor decodes every frame.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME_CYC = NB * CPB;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [10:0] mon_lv [$];
    int          mon_st [$];
    bit          mon_ok [$];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Frame decoder: each level must hold CPB cycles with busy high.
    initial begin : line_mon
        logic [10:0] lv;
        bit          ok;
        int          st;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                st = cyc;
                ok = 1'b1;
                lv = '0;
                for (int k = 0; k < NB; k++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        if (c == 0) lv[k] = tx;
                        else if (tx !== lv[k]) ok = 1'b0;
                        if (busy !== 1'b1) ok = 1'b0;
                    end
                end
                if (lv[0] !== 1'b0 || lv[NB-1] !== 1'b1) ok = 1'b0;
                mon_lv.push_back(lv);
                mon_st.push_back(st);
                mon_ok.push_back(ok);
            end
        end
    end

    task automatic wait_busy_low(input string tag, input int max);
        int i;
        i = 0;
        while (busy && i < max) begin
            @(negedge clk);
            i++;
        end
        chk({tag, " busy drop"}, busy, 0);
    endtask

    task automatic quiet_window(input string tag, input int len);
        int lows;
        lows = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk({tag, " line quiet"}, lows, 0);
    endtask

    task automatic push_seq(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // One byte from idle/empty: latency, busy length and decoded content.
    task automatic single(input string tag, input logic [7:0] b, output logic [10:0] lv_out);
        int n;
        int base;
        logic [10:0] lv;
        base = mon_lv.size();
        push_seq(b);
        chk({tag, " tx at accept"}, tx, 1);
        chk({tag, " count at accept"}, fifo_count, 1);
        @(negedge clk);
        chk({tag, " tx start"}, tx, 0);
        chk({tag, " busy start"}, busy, 1);
        chk({tag, " count after pop"}, fifo_count, 0);
        n = 1;
        for (int i = 0; i < 4 * FRAME_CYC && busy; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk({tag, " busy cycles"}, n, FRAME_CYC);
        chk({tag, " tx idle after"}, tx, 1);
        chk({tag, " frames seen"}, mon_lv.size(), base + 1);
        lv = mon_lv[base];
        chk({tag, " data"}, lv[8:1], b);
        chk({tag, " shape"}, mon_ok[base], 1);
        lv_out = lv;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        logic [10:0] lv;
        int base;
        rst_n    = 1'b0;
        ena      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        repeat (3) @(negedge clk);
        chk("reset tx", tx, 1);
        chk("reset busy", busy, 0);
        chk("reset count", fifo_count, 0);
        wr_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("post reset wr_ready", wr_ready, 1);
        chk("post reset count", fifo_count, 0);

        // Single byte 0x55
        single("t1", 8'h55, lv);

        // Fill the FIFO, sixth push dropped, five gap-free frames
        base = mon_lv.size();
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin
                chk("t2 count full", fifo_count, 4);
                chk("t2 wr_ready full", wr_ready, 0);
            end
            wr_data  = 8'(i);
            wr_valid = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("t2 count after drop", fifo_count, 4);
        wait_busy_low("t2", 6 * FRAME_CYC);
        chk("t2 frames", mon_lv.size(), base + 5);
        for (int i = 0; i < 5; i++) begin
            lv = mon_lv[base+i];
            chk($sformatf("t2 data%0d", i), lv[8:1], i + 1);
            chk($sformatf("t2 shape%0d", i), mon_ok[base+i], 1);
            if (i > 0) chk($sformatf("t2 gap%0d", i), mon_st[base+i] - mon_st[base+i-1], FRAME_CYC);
        end

        // ena dropped during data bits of 0xA3
        base = mon_lv.size();
        push_seq(8'hA3);
        push_seq(8'h3C);
        chk("t3 count", fifo_count, 1);
        repeat (8) @(negedge clk);
        ena = 1'b0;
        #1;
        chk("t3 wr_ready off", wr_ready, 0);
        push_seq(8'hEE);
        wait_busy_low("t3", 2 * FRAME_CYC);
        chk("t3 count retained", fifo_count, 1);
        chk("t3 frames", mon_lv.size(), base + 1);
        lv = mon_lv[base];
        chk("t3 data A3", lv[8:1], 8'hA3);
        quiet_window("t3 paused", 60);
        chk("t3 count still", fifo_count, 1);
        ena = 1'b1;
        @(negedge clk);
        chk("t3 resume busy", busy, 1);
        wait_busy_low("t3 resume", 2 * FRAME_CYC);
        chk("t3 frames after", mon_lv.size(), base + 2);
        lv = mon_lv[base+1];
        chk("t3 data 3C", lv[8:1], 8'h3C);
        chk("t3 count empty", fifo_count, 0);

        // Parity bit content and single-frame length
        single("t5a", 8'h07, lv);
`ifdef UART_TX_PARITY_EN
        chk("t5a parity", lv[9], 1);
`endif
        single("t5b", 8'h03, lv);
`ifdef UART_TX_PARITY_EN
        chk("t5b parity", lv[9], 0);
`endif

        // Push coinciding with the STOP->START pop
        base = mon_lv.size();
        push_seq(8'h41);
        push_seq(8'h42);
        chk("t6 count", fifo_count, 1);
        repeat (FRAME_CYC - 1) @(negedge clk);
        chk("t6 last stop busy", busy, 1);
        chk("t6 last stop tx", tx, 1);
        push_seq(8'h43);
        chk("t6 count same", fifo_count, 1);
        chk("t6 back-to-back start", tx, 0);
        wait_busy_low("t6", 4 * FRAME_CYC);
        chk("t6 frames", mon_lv.size(), base + 3);
        for (int i = 0; i < 3; i++) begin
            lv = mon_lv[base+i];
            chk($sformatf("t6 data%0d", i), lv[8:1], 8'h41 + i);
            if (i > 0) chk($sformatf("t6 gap%0d", i), mon_st[base+i] - mon_st[base+i-1], FRAME_CYC);
        end

        // Reset during bit 3 of 0xF0 with two bytes queued
        push_seq(8'hF0);
        push_seq(8'h11);
        push_seq(8'h22);
        chk("t4 count queued", fifo_count, 2);
        repeat (16) @(negedge clk);
        chk("t4 bit3 level", tx, 0);
        rst_n    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        @(negedge clk);
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        chk("t4 tx after reset", tx, 1);
        chk("t4 busy after reset", busy, 0);
        chk("t4 count after reset", fifo_count, 0);
        quiet_window("t4", 100);
        chk("t4 busy stays low", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Serial transmit stage downstream of the `tt_um_first_asic` core logic. It accepts bytes from the core over a valid/ready handshake and buffers them in a small FIFO. It serialises each byte as an 8N1 UART frame on a single `uo_out` pin. It lets the chip report results to a host without an external shift register.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Minimum 2.
- `FIFO_DEPTH`, default 4: byte entries. Power of two, 2–16.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset. Sampled on rising edge of `clk`.
- `ena` in 1: block enable from the TT harness.
- `wr_data` in 8: byte to transmit.
- `wr_valid` in 1: `wr_data` is valid.
- `wr_ready` out 1: FIFO can accept a byte. Combinational: `ena && (fifo_count < FIFO_DEPTH)`.
- `tx` out 1: UART line, idle high. Registered.
- `busy` out 1: a frame is in progress. Registered.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: bytes currently buffered, excluding the byte being shifted.

## Operation
- Reset (`rst_n`=0 at an edge):
  - `tx`=1, `busy`=0, `fifo_count`=0.
  - FIFO pointers = 0, FSM = IDLE, baud counter = 0, bit index = 0.
  - `wr_valid` is ignored in any cycle where `rst_n`=0.
- Push: at an edge where `wr_valid && wr_ready && rst_n`, `wr_data` is written at the write pointer and the pointer increments mod `FIFO_DEPTH`.
- Pop: performed by the FSM when loading the shift register. The read pointer increments mod `FIFO_DEPTH`.
- Push and pop on the same edge: `fifo_count` is unchanged.
- Full: `wr_ready`=0, so no push occurs, even if a pop happens on the same edge.
- FSM states and transitions:
  - IDLE: `tx`=1, `busy`=0. If `ena` and FIFO non-empty: pop, load the shift register, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=shift[0], LSB first. The register shifts right every `CLKS_PER_BIT` cycles. After 8 bits go to PARITY if enabled, otherwise STOP.
  - PARITY: `tx`=XOR of the 8 data bits (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On the last cycle:
    - if `ena` and FIFO non-empty: pop, load, go to START. Back-to-back frames, no idle bit.
    - otherwise go to IDLE.
- `busy`=1 in START, DATA, PARITY and STOP.
- `ena` deasserted mid-frame: the current frame completes normally. No new frame starts and no pushes are accepted. Buffered bytes are retained.
- Reset mid-frame: `tx` returns to 1 on that edge and the FIFO is flushed. The partial frame is abandoned.
- Baud counter: counts 0..`CLKS_PER_BIT`-1, wraps to 0 at each bit boundary, and resets to 0 on every state entry.

## Timing
- Push-to-line latency from IDLE with an empty FIFO:
  - byte accepted at edge E0;
  - FSM pops at edge E1, and `tx` falls and `busy` rises after E1;
  - first-byte latency is 1 cycle.
- `fifo_count` reflects a push one cycle after the accepting edge.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- Back-to-back frame period equals the frame length exactly.
- `busy` falls on the edge that ends STOP when the FIFO is empty.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: frames are 8E1. The PARITY state is compiled in and an even-parity bit is sent between bit 7 and stop.
  - Undefined: frames are 8N1. The PARITY state and parity logic are absent.

## Test plan
1. Single byte, `CLKS_PER_BIT`=4, no parity:
   - Stimulus: push 0x55 from idle.
   - Required: `tx` low one cycle after acceptance. Line sequence 0,1,0,1,0,1,0,1,0,1, each level 4 cycles. `busy` high for exactly 40 cycles.
2. Fill FIFO, `FIFO_DEPTH`=4:
   - Stimulus: push 0x01..0x05 on consecutive cycles.
   - Required: 0x01 is popped immediately, 0x02–0x05 are buffered, `fifo_count`=4 and `wr_ready`=0. A 6th push attempt is dropped. Five frames leave with no idle gap between them.
3. `ena` drop:
   - Stimulus: push 0xA3 and 0x3C, then deassert `ena` during the 0xA3 data bits.
   - Required: the 0xA3 frame completes. `busy`=0 and `fifo_count`=1 afterwards. 0x3C is sent after `ena` is reasserted.
4. Reset mid-frame:
   - Stimulus: assert `rst_n`=0 for 1 cycle during bit 3 of 0xF0 with 2 bytes queued.
   - Required: `tx`=1, `busy`=0 and `fifo_count`=0 after that edge. No further frames are sent.
5. Parity (`UART_TX_PARITY_EN`):
   - Stimulus: push 0x07.
   - Required: parity bit 1 and frame length 44 cycles.
   - Stimulus: push 0x03.
   - Required: parity bit 0.
6. Simultaneous push and pop:
   - Stimulus: FIFO holds 1 byte, and a push coincides with the STOP→START pop.
   - Required: `fifo_count` stays 1 and the byte order is preserved.
